// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store sequencer: access encodings,
// sequencer states and the alignment rule also used by EX-stage hazard logic.
package mem_access_ctrl_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_ADDR  = 3'd1,
    LD_DATA  = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_e;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic misaligned(input logic [2:0] memop, input logic [1:0] a);
    case (memop)
      MEMOP_H, MEMOP_HU: misaligned = a[0];
      MEMOP_W:           misaligned = |a;
      default:           misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: one request at a time, matched to the data memory's
// registered read and its negedge read-modify-write for sub-word stores.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_memop,
  input  logic [31:0]       req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [2:0]        mem_memop,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  output logic              wb_is_load,
  output logic              wb_misalign,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data
);

  state_e     state, state_n;
  logic [4:0] rd_q;
  logic       accept, mis, go, ld_done, st_done, mis_fire;
  logic       unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_W];

  assign req_ready = (state == IDLE) && !flush;
  assign mem_we    = (state == ST_WRITE);
  assign accept    = req_valid && req_ready;
  assign mis       = misaligned(req_memop, req_addr[1:0]);

  always_comb begin
    state_n  = state;
    go       = 1'b0;
    ld_done  = 1'b0;
    st_done  = 1'b0;
    mis_fire = 1'b0;
    case (state)
      IDLE: begin
        mis_fire = accept && mis;
        go       = accept && !mis;
        if (go) begin
          if (!req_we)                 state_n = LD_ADDR;
          else if (req_memop == MEMOP_W) state_n = ST_WRITE;
          else                         state_n = ST_READ;
        end
      end
      LD_ADDR:  state_n = flush ? IDLE : LD_DATA;
      LD_DATA: begin
        state_n = IDLE;
        ld_done = !flush;
      end
      ST_READ:  state_n = flush ? IDLE : ST_WRITE;
      ST_WRITE: begin
        // The write has already landed at the negedge; flush only hides completion.
        state_n = IDLE;
        st_done = !flush;
      end
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_addr    <= '0;
      mem_memop   <= '0;
      mem_wdata   <= '0;
      rd_q        <= '0;
      wb_valid    <= 1'b0;
      wb_is_load  <= 1'b0;
      wb_misalign <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
    end else begin
      state    <= state_n;
      wb_valid <= ld_done || st_done || mis_fire;
      if (go) begin
        mem_addr  <= req_addr[ADDR_W-1:0];
        mem_memop <= req_memop;
        mem_wdata <= req_wdata;
        rd_q      <= req_rd;
      end
      if (ld_done) begin
        wb_is_load  <= 1'b1;
        wb_misalign <= 1'b0;
        wb_rd       <= rd_q;
        wb_data     <= mem_rdata;
      end else if (st_done) begin
        wb_is_load  <= 1'b0;
        wb_misalign <= 1'b0;
        wb_rd       <= rd_q;
        wb_data     <= '0;
      end else if (mis_fire) begin
        wb_is_load  <= !req_we;
        wb_misalign <= 1'b1;
        wb_rd       <= req_rd;
        wb_data     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural data memory
// (registered read, negedge merge of sub-word stores into the latched old word).
module tb_mem_access_ctrl;

  localparam int ADDR_W = 18;
  localparam int XLEN   = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_we, flush;
  logic [2:0]        req_memop;
  logic [31:0]       req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [4:0]        req_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [2:0]        mem_memop;
  logic [XLEN-1:0]   mem_wdata, mem_rdata;
  logic              wb_valid, wb_is_load, wb_misalign;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int we0;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_memop(req_memop), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .flush(flush),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_memop(mem_memop),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_is_load(wb_is_load), .wb_misalign(wb_misalign),
    .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // Behavioural memory, 16 words
  logic [31:0] mem [0:15];
  logic [31:0] rword, rdata_q;
  logic        bd_we = 1'b0;
  logic [3:0]  bd_idx;
  logic [31:0] bd_data;

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] op, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * a));
    h = 16'(w >> (16 * a[1]));
    case (op)
      3'b000:  ext = {{24{b[7]}}, b};
      3'b001:  ext = {{16{h[15]}}, h};
      3'b100:  ext = {24'd0, b};
      3'b101:  ext = {16'd0, h};
      default: ext = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [2:0] op, input logic [1:0] a);
    logic [31:0] r;
    r = old;
    case (op)
      3'b000:  r[8*a +: 8] = d[7:0];
      3'b001:  r[16*a[1] +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    rword   <= mem[mem_addr[5:2]];
    rdata_q <= ext(mem[mem_addr[5:2]], mem_memop, mem_addr[1:0]);
  end
  assign mem_rdata = rdata_q;

  always @(negedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (mem_we) begin
      mem[mem_addr[5:2]] <= merge(rword, mem_wdata, mem_memop, mem_addr[1:0]);
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [3:0] idx, input logic [31:0] d);
    bd_idx = idx; bd_data = d; bd_we = 1'b1;
    @(negedge clk);
    #1 bd_we = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd);
    req_valid = 1'b1; req_we = we; req_memop = op; req_addr = a; req_wdata = d; req_rd = rd;
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [4:0] rd, input logic [31:0] exp);
    issue(1'b0, op, a, 32'h0, rd);
    chk({tag, "_rdy_c1"}, 32'(req_ready), 32'd0);
    chk({tag, "_we_c1"}, 32'(mem_we), 32'd0);
    step();
    chk({tag, "_rdy_c2"}, 32'(req_ready), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(wb_valid), 32'd1);
    chk({tag, "_data"}, wb_data, exp);
    chk({tag, "_isload"}, 32'(wb_is_load), 32'd1);
    chk({tag, "_rd"}, 32'(wb_rd), 32'(rd));
    chk({tag, "_mis"}, 32'(wb_misalign), 32'd0);
    chk({tag, "_rdy_c3"}, 32'(req_ready), 32'd1);
    step();
    chk({tag, "_pulse"}, 32'(wb_valid), 32'd0);
    chk({tag, "_hold"}, wb_data, exp);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_memop = 3'b000; req_addr = '0; req_wdata = '0; req_rd = '0;
    for (int i = 0; i < 16; i++) poke(4'(i), 32'h0);
    poke(4'd4, 32'hDEADBEEF);
    poke(4'd1, 32'h11223344);
    step();
    chk("rst_valid", 32'(wb_valid), 32'd0);
    chk("rst_data", wb_data, 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_we", 32'(mem_we), 32'd0);
    rst = 1'b0;
    #1 chk("rst_ready", 32'(req_ready), 32'd1);

    do_load("lw10", 3'b010, 32'h10, 5'd5, 32'hDEADBEEF);

    // SB into byte lane 1 of word 1
    we0 = we_cnt;
    issue(1'b1, 3'b000, 32'h5, 32'h000000AA, 5'd6);
    chk("sb_read_we", 32'(mem_we), 32'd0);
    chk("sb_read_rdy", 32'(req_ready), 32'd0);
    step();
    chk("sb_write_we", 32'(mem_we), 32'd1);
    step();
    chk("sb_we_off", 32'(mem_we), 32'd0);
    chk("sb_valid", 32'(wb_valid), 32'd1);
    chk("sb_isload", 32'(wb_is_load), 32'd0);
    chk("sb_data", wb_data, 32'h0);
    chk("sb_rd", 32'(wb_rd), 32'd6);
    chk("sb_wecnt", 32'(we_cnt - we0), 32'd1);
    do_load("lw4", 3'b010, 32'h4, 5'd1, 32'h1122AA44);

    we0 = we_cnt;
    issue(1'b1, 3'b010, 32'h8, 32'hCAFEF00D, 5'd2);
    chk("sw_we", 32'(mem_we), 32'd1);
    step();
    chk("sw_we_off", 32'(mem_we), 32'd0);
    chk("sw_valid", 32'(wb_valid), 32'd1);
    chk("sw_isload", 32'(wb_is_load), 32'd0);
    chk("sw_wecnt", 32'(we_cnt - we0), 32'd1);
    step();
    chk("sw_pulse", 32'(wb_valid), 32'd0);
    do_load("lw8", 3'b010, 32'h8, 5'd3, 32'hCAFEF00D);

    // Reset during LD_ADDR
    poke(4'd1, 32'h80000000);
    issue(1'b0, 3'b010, 32'h4, 32'h0, 5'd11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_valid", 32'(wb_valid), 32'd0);
    chk("mrst_data", wb_data, 32'h0);
    chk("mrst_isload", 32'(wb_is_load), 32'd0);
    chk("mrst_rd", 32'(wb_rd), 32'd0);
    chk("mrst_addr", 32'(mem_addr), 32'h0);
    chk("mrst_wdata", mem_wdata, 32'h0);
    chk("mrst_memop", 32'(mem_memop), 32'd0);
    #1 chk("mrst_ready", 32'(req_ready), 32'd1);
    step();
    chk("mrst_novalid", 32'(wb_valid), 32'd0);
    do_load("lbu7", 3'b100, 32'h7, 5'd12, 32'h00000080);

    // Misaligned requests complete at the accept edge
    we0 = we_cnt;
    issue(1'b0, 3'b001, 32'h3, 32'h0, 5'd7);
    chk("lh3_valid", 32'(wb_valid), 32'd1);
    chk("lh3_mis", 32'(wb_misalign), 32'd1);
    chk("lh3_isload", 32'(wb_is_load), 32'd1);
    chk("lh3_rd", 32'(wb_rd), 32'd7);
    chk("lh3_data", wb_data, 32'h0);
    chk("lh3_ready", 32'(req_ready), 32'd1);
    issue(1'b1, 3'b010, 32'h6, 32'h12345678, 5'd8);
    chk("sw6_valid", 32'(wb_valid), 32'd1);
    chk("sw6_mis", 32'(wb_misalign), 32'd1);
    chk("sw6_isload", 32'(wb_is_load), 32'd0);
    chk("sw6_rd", 32'(wb_rd), 32'd8);
    chk("sw6_ready", 32'(req_ready), 32'd1);
    step();
    chk("sw6_pulse", 32'(wb_valid), 32'd0);
    chk("mis_wecnt", 32'(we_cnt - we0), 32'd0);

    // LB flushed in LD_DATA
    issue(1'b0, 3'b000, 32'h10, 32'h0, 5'd9);
    step();
    flush = 1'b1;
    step();
    chk("lbfl_valid", 32'(wb_valid), 32'd0);
    flush = 1'b0;
    #1 chk("lbfl_ready", 32'(req_ready), 32'd1);
    step();
    chk("lbfl_valid2", 32'(wb_valid), 32'd0);

    // SH flushed in ST_READ
    we0 = we_cnt;
    issue(1'b1, 3'b001, 32'h10, 32'h00005555, 5'd10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("shfl_we", 32'(mem_we), 32'd0);
    chk("shfl_valid", 32'(wb_valid), 32'd0);
    step();
    chk("shfl_valid2", 32'(wb_valid), 32'd0);
    chk("shfl_wecnt", 32'(we_cnt - we0), 32'd0);
    chk("shfl_mem", mem[4], 32'hDEADBEEF);

    // flush beats a simultaneous request
    req_valid = 1'b1; req_we = 1'b0; req_memop = 3'b010; req_addr = 32'h8; req_rd = 5'd13;
    flush = 1'b1;
    #1 chk("flreq_ready", 32'(req_ready), 32'd0);
    step();
    req_valid = 1'b0; flush = 1'b0;
    chk("flreq_addr", 32'(mem_addr), 32'h10);
    step();
    step();
    chk("flreq_valid", 32'(wb_valid), 32'd0);
    chk("flreq_ready2", 32'(req_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage load/store sequencer for the pipelined CPU. Sits directly upstream of the data memory and feeds its addr/we/MemOp/datain inputs.
- Accepts one EX/MEM request at a time and performs a misalignment check.
- Sequences the memory's registered-read timing and its negedge read-modify-write for sub-word stores.
- Produces the MEM/WB result pulse: load data or store completion.

Parameters:
- ADDR_W, 18, width of the memory byte address driven to the memory (word index = addr[ADDR_W-1:2]).
- XLEN, 32, data width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  EX/MEM request present.
- req_ready  output  1  block can accept; high only in IDLE with flush=0.
- req_we  input  1  1=store, 0=load.
- req_memop  input  3  access type: 000 LB, 001 LH, 010 LW/SW, 100 LBU, 101 LHU (SB/SH use 000/001).
- req_addr  input  32  byte address; only [ADDR_W-1:0] used.
- req_wdata  input  XLEN  store data, low-aligned.
- req_rd  input  5  destination register tag.
- flush  input  1  pipeline kill.
- mem_addr  output  ADDR_W  to memory addr.
- mem_we  output  1  to memory we.
- mem_memop  output  3  to memory MemOp.
- mem_wdata  output  XLEN  to memory datain.
- mem_rdata  input  XLEN  from memory dataout (already extended/selected).
- wb_valid  output  1  one-cycle result pulse.
- wb_is_load  output  1  result is load data.
- wb_misalign  output  1  request rejected as misaligned; no memory access.
- wb_rd  output  5  tag of the completed request.
- wb_data  output  XLEN  load data (0 for stores/misaligned).

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; mem_we=0; mem_addr=0, mem_memop=0, mem_wdata=0.
  - All wb_* outputs = 0. Any in-flight request dropped; rst overrides flush.
- Accept: edge where req_valid && req_ready. Registers we/memop/addr/wdata/rd and drives them onto mem_* from the next cycle.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - At the accept edge: wb_valid=1, wb_misalign=1, wb_rd=req_rd, wb_data=0, wb_is_load=req_we^1.
  - State stays IDLE; mem_we never asserted.
- States: IDLE, LD_ADDR, LD_DATA, ST_READ, ST_WRITE.
  - Load: IDLE -> LD_ADDR -> LD_DATA -> IDLE.
    - LD_ADDR: mem_addr stable, mem_we=0; the memory latches the word at the end of the cycle.
    - LD_DATA: mem_rdata valid; captured into wb_data at the end-of-cycle edge.
    - wb_valid=1, wb_is_load=1 in the following cycle. Latency is accept edge + 2 edges.
  - Word store: IDLE -> ST_WRITE -> IDLE. ST_WRITE holds mem_we=1 for exactly one cycle.
  - Sub-word store (memop 000/001): IDLE -> ST_READ -> ST_WRITE -> IDLE.
    - ST_READ presents the address with mem_we=0 so the memory's old-word register is valid before its negedge merge in ST_WRITE.
  - Store completion: wb_valid=1, wb_is_load=0, wb_data=0 in the cycle after ST_WRITE.
- mem_we=1 only in ST_WRITE. mem_addr/mem_memop/mem_wdata hold their last values in IDLE.
- wb_valid is a single-cycle pulse. Other wb_* fields hold until the next pulse.
- req_ready=0 in every non-IDLE state. Maximum throughput: one load per 3 cycles.
- flush=1 at an edge:
  - IDLE: no accept; misaligned pulse also suppressed.
  - LD_ADDR / LD_DATA / ST_READ: go to IDLE, no write, no wb_valid.
  - ST_WRITE: the memory write already occurred at that cycle's negedge. Go to IDLE but suppress wb_valid.
- Simultaneous flush and req_valid: flush wins, nothing accepted.

Decomposition:
- Shared package:
  - MEMOP_B=3'b000, MEMOP_H=3'b001, MEMOP_W=3'b010, MEMOP_BU=3'b100, MEMOP_HU=3'b101.
  - State enum.
  - Misalignment function (memop, addr[1:0]) -> bit, reused by the EX-stage hazard logic.
- Single module; no sub-module needed.

Test Plan:
- Reset then LW addr=0x00010, memory word 4=0xDEADBEEF -> req_ready low 2 cycles; wb_valid 3rd cycle after accept with wb_data=0xDEADBEEF, wb_is_load=1.
- SB wdata=0x000000AA addr=0x00005 over word 0x11223344 -> ST_READ then one-cycle mem_we; following LW addr 0x4 returns 0x1122AA44.
- SW 0xCAFEF00D addr=0x8 -> exactly one mem_we cycle, wb_valid next cycle, wb_is_load=0; LW 0x8 returns 0xCAFEF00D.
- LH addr=0x3 and SW addr=0x6 -> same-edge wb_valid with wb_misalign=1, mem_we never high, state stays IDLE.
- LB flushed in LD_DATA -> no wb_valid, req_ready high next cycle. SH flushed in ST_READ -> memory unchanged.
- rst asserted mid LD_ADDR -> next cycle all outputs 0, IDLE, subsequent LBU addr=0x7 on 0x80000000 returns 0x00000080.
